alu_requester: RTL and testbench

ALU_REQUESTER -- requirements
Module: alu_requester

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_requester.sv | 93 +++++++++
 tb/tb_alu_requester.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU requester: opcodes, widths and FSM encoding.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int RES_W  = 32;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 3;
  localparam int CNT_W  = 3;

  localparam logic [OP_W-1:0] OP_AND     = 3'b000;
  localparam logic [OP_W-1:0] OP_OR      = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD     = 3'b010;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 3'b011;
  localparam logic [OP_W-1:0] OP_ANDN    = 3'b100;
  localparam logic [OP_W-1:0] OP_ORN     = 3'b101;
  localparam logic [OP_W-1:0] OP_SUB     = 3'b110;
  localparam logic [OP_W-1:0] OP_SLT     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return op == OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_requester.sv
// Single-outstanding request front end for a fixed-latency ALU: latches operands,
// waits out the ALU pipeline, and holds the captured result until it is consumed.
module alu_requester
  import alu_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [OP_W-1:0]   req_op,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] ScrA,
  output logic [DATA_W-1:0] ScrB,
  output logic [OP_W-1:0]   AluControl,
  input  logic [RES_W-1:0]  ALUResult,
  input  logic              zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic [15:0]       rsp_count
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             illegal_q;
  logic             accept, handshake;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign handshake = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept)      state_nx = ST_WAIT;
      ST_WAIT: if (cnt == '0)   state_nx = ST_RESP;
      ST_RESP: if (handshake)   state_nx = ST_IDLE;
      default:                  state_nx = ST_IDLE;
    endcase
  end

  // Illegal ops load a zero count so they spend exactly one cycle before RESP,
  // and their response is synthesized instead of sampled from the ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      ScrA       <= '0;
      ScrB       <= '0;
      AluControl <= '0;
      cnt        <= '0;
      illegal_q  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
      rsp_count  <= '0;
    end else begin
      if (accept) begin
        ScrA       <= req_a;
        ScrB       <= req_b;
        AluControl <= is_illegal(req_op) ? OP_AND : req_op;
        cnt        <= is_illegal(req_op) ? '0 : LAT;
        illegal_q  <= is_illegal(req_op);
        rsp_tag    <= req_tag;
        rsp_err    <= is_illegal(req_op);
      end
      if (state == ST_WAIT) begin
        if (cnt == '0) begin
          rsp_result <= illegal_q ? '0 : ALUResult;
          rsp_zero   <= illegal_q ? 1'b1 : zero;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
      if (handshake) rsp_count <= rsp_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_requester.sv
// Randomized self-checking bench for alu_requester with registered stub ALUs
// (one instance at LATENCY=1, one at LATENCY=3).
module tb_alu_requester;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_count;

  // LATENCY=1 instance
  logic        req_valid, req_ready, rsp_valid, rsp_ready, zero, rsp_zero, rsp_err;
  logic [15:0] req_a, req_b, ScrA, ScrB, rsp_count;
  logic [2:0]  req_op, AluControl;
  logic [3:0]  req_tag, rsp_tag;
  logic [31:0] ALUResult, rsp_result;

  // LATENCY=3 instance
  logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, zero3, rsp_zero3, rsp_err3;
  logic [15:0] req_a3, req_b3, ScrA3, ScrB3, rsp_count3;
  logic [2:0]  req_op3, AluControl3;
  logic [3:0]  req_tag3, rsp_tag3;
  logic [31:0] ALUResult3, rsp_result3;

  alu_requester #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .ScrA(ScrA), .ScrB(ScrB), .AluControl(AluControl),
    .ALUResult(ALUResult), .zero(zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .rsp_count(rsp_count)
  );

  alu_requester #(.LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_op(req_op3), .req_tag(req_tag3),
    .ScrA(ScrA3), .ScrB(ScrB3), .AluControl(AluControl3),
    .ALUResult(ALUResult3), .zero(zero3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_zero(rsp_zero3), .rsp_tag(rsp_tag3), .rsp_err(rsp_err3), .rsp_count(rsp_count3)
  );

  // Stub ALUs: registered concatenation, zero when operands match
  logic [31:0] p3_res [0:2];
  logic        p3_z   [0:2];
  initial begin
    ALUResult = '0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin p3_res[i] = '0; p3_z[i] = 1'b0; end
  end
  always @(posedge clk) begin
    ALUResult <= {ScrA, ScrB};
    zero      <= (ScrA == ScrB);
    p3_res[0] <= {ScrA3, ScrB3};
    p3_z[0]   <= (ScrA3 == ScrB3);
    p3_res[1] <= p3_res[0];
    p3_z[1]   <= p3_z[0];
    p3_res[2] <= p3_res[1];
    p3_z[2]   <= p3_z[1];
  end
  assign ALUResult3 = p3_res[2];
  assign zero3      = p3_z[2];

  // Present a request for one edge, then count edges until rsp_valid rises
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                      input logic [3:0] tag, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_tag = tag;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_count = '0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    checks++; if ({ScrA, ScrB, AluControl} !== 35'd0) begin failures++; $display("FAIL reset_alu_ops got=%h/%h/%h exp=0", ScrA, ScrB, AluControl); end
    checks++; if ({rsp_result, rsp_zero, rsp_tag, rsp_err} !== 38'd0) begin failures++; $display("FAIL reset_rsp got=%h/%b/%h/%b exp=0", rsp_result, rsp_zero, rsp_tag, rsp_err); end
    checks++; if (rsp_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", rsp_count); end
  endtask

  task automatic test_basic();
    int lat;
    send(16'hAAAA, 16'h5555, 3'b000, 4'd3, lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    checks++; if (rsp_result !== 32'hAAAA5555) begin failures++; $display("FAIL basic_result got=%h exp=aaaa5555", rsp_result); end
    checks++; if ({rsp_zero, rsp_err} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b%b exp=00", rsp_zero, rsp_err); end
    checks++; if (rsp_tag !== 4'd3) begin failures++; $display("FAIL basic_tag got=%0d exp=3", rsp_tag); end
    checks++; if (AluControl !== 3'b000) begin failures++; $display("FAIL basic_aluctl got=%b exp=000", AluControl); end
    ack();
    checks++; if (rsp_count !== exp_count) begin failures++; $display("FAIL basic_count got=%h exp=%h", rsp_count, exp_count); end
  endtask

  task automatic test_equal();
    int lat;
    send(16'h0003, 16'h0003, 3'b111, 4'd5, lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL equal_latency got=%0d exp=2", lat); end
    checks++; if (rsp_result !== 32'h00030003) begin failures++; $display("FAIL equal_result got=%h exp=00030003", rsp_result); end
    checks++; if (rsp_zero !== 1'b1) begin failures++; $display("FAIL equal_zero got=%b exp=1", rsp_zero); end
    checks++; if (AluControl !== 3'b111) begin failures++; $display("FAIL equal_aluctl got=%b exp=111", AluControl); end
    ack();
    checks++; if (rsp_count !== exp_count) begin failures++; $display("FAIL equal_count got=%h exp=%h", rsp_count, exp_count); end
  endtask

  task automatic test_illegal();
    int lat;
    send(16'h1234, 16'h5678, 3'b011, 4'd9, lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
    checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", rsp_err); end
    checks++; if (rsp_result !== 32'd0) begin failures++; $display("FAIL illegal_result got=%h exp=0", rsp_result); end
    checks++; if (rsp_zero !== 1'b1) begin failures++; $display("FAIL illegal_zero got=%b exp=1", rsp_zero); end
    checks++; if (rsp_tag !== 4'd9) begin failures++; $display("FAIL illegal_tag got=%0d exp=9", rsp_tag); end
    checks++; if (AluControl !== 3'b000) begin failures++; $display("FAIL illegal_aluctl got=%b exp=000", AluControl); end
    ack();
  endtask

  task automatic test_backpressure();
    int lat;
    send(16'hBEEF, 16'h0102, 3'b010, 4'd6, lat);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2 == 0); req_a = 16'hFFFF; req_b = 16'h1111; req_op = 3'b001; req_tag = 4'd1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== 32'hBEEF0102 ||
          rsp_tag !== 4'd6 || rsp_err !== 1'b0 || ScrA !== 16'hBEEF || AluControl !== 3'b010) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d got v=%b rdy=%b res=%h tag=%0d scra=%h exp v=1 rdy=0 res=beef0102 tag=6 scra=beef",
                 i, rsp_valid, req_ready, rsp_result, rsp_tag, ScrA);
      end
    end
    req_valid = 1'b0;
    ack();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL backpressure_release got rdy=%b v=%b exp rdy=1 v=0", req_ready, rsp_valid); end
    checks++; if (ScrA !== 16'hBEEF || ScrB !== 16'h0102) begin failures++; $display("FAIL backpressure_noaccept got=%h/%h exp=beef/0102", ScrA, ScrB); end
  endtask

  task automatic test_back_to_back();
    int lat;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (rsp_count !== exp_count || rsp_valid !== 1'b0) begin failures++; $display("FAIL idle_ready_noeffect got cnt=%h v=%b exp cnt=%h v=0", rsp_count, rsp_valid, exp_count); end
    send(16'h0F0F, 16'hF0F0, 3'b100, 4'd2, lat);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_a = 16'h7777; req_b = 16'h7777; req_op = 3'b101; req_tag = 4'd12;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || ScrA !== 16'h0F0F) begin failures++; $display("FAIL b2b_idle got rdy=%b v=%b scra=%h exp rdy=1 v=0 scra=0f0f", req_ready, rsp_valid, ScrA); end
    checks++; if (rsp_count !== exp_count) begin failures++; $display("FAIL b2b_count got=%h exp=%h", rsp_count, exp_count); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0 || ScrA !== 16'h7777 || AluControl !== 3'b101) begin failures++; $display("FAIL b2b_accept got rdy=%b scra=%h ctl=%b exp rdy=0 scra=7777 ctl=101", req_ready, ScrA, AluControl); end
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat != 2 || rsp_result !== 32'h77777777 || rsp_zero !== 1'b1 || rsp_tag !== 4'd12) begin
      failures++; $display("FAIL b2b_second got lat=%0d res=%h z=%b tag=%0d exp lat=2 res=77777777 z=1 tag=12", lat, rsp_result, rsp_zero, rsp_tag);
    end
    ack();
  endtask

  task automatic test_random();
    int lat, stall;
    logic [15:0] a, b;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic        bad;
    for (int n = 0; n < 40; n++) begin
      a   = 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      op  = 3'($urandom_range(0, 7));
      tag = 4'($urandom);
      bad = (op == 3'b011);
      send(a, b, op, tag, lat);
      checks++;
      if (lat != (bad ? 1 : 2) || rsp_result !== (bad ? 32'd0 : {a, b}) ||
          rsp_zero !== (bad ? 1'b1 : (a == b)) || rsp_err !== bad || rsp_tag !== tag ||
          AluControl !== (bad ? 3'b000 : op)) begin
        failures++;
        $display("FAIL random_txn n=%0d got lat=%0d res=%h z=%b err=%b tag=%0d ctl=%b exp a=%h b=%h op=%b tag=%0d",
                 n, lat, rsp_result, rsp_zero, rsp_err, rsp_tag, AluControl, a, b, op, tag);
      end
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      ack();
      checks++; if (rsp_count !== exp_count) begin failures++; $display("FAIL random_count n=%0d got=%h exp=%h", n, rsp_count, exp_count); end
    end
  endtask

  task automatic test_latency3();
    int lat;
    logic [15:0] a, b;
    for (int n = 0; n < 3; n++) begin
      a = 16'($urandom);
      b = (n == 1) ? a : 16'($urandom);
      @(negedge clk);
      req_valid3 = 1'b1; req_a3 = a; req_b3 = b; req_op3 = 3'b110; req_tag3 = 4'(n + 4);
      @(posedge clk);
      @(negedge clk);
      req_valid3 = 1'b0;
      lat = 0;
      while (!rsp_valid3 && lat < 20) begin @(negedge clk); lat++; end
      checks++;
      if (lat != 4 || rsp_result3 !== {a, b} || rsp_zero3 !== (a == b) || rsp_tag3 !== 4'(n + 4) || rsp_err3 !== 1'b0) begin
        failures++;
        $display("FAIL lat3_txn n=%0d got lat=%0d res=%h z=%b tag=%0d exp lat=4 res=%h%h z=%b", n, lat, rsp_result3, rsp_zero3, rsp_tag3, a, b, a == b);
      end
      rsp_ready3 = 1'b1;
      @(negedge clk);
      rsp_ready3 = 1'b0;
      checks++; if (rsp_count3 !== 16'(n + 1)) begin failures++; $display("FAIL lat3_count got=%h exp=%0d", rsp_count3, n + 1); end
    end
  endtask

  task automatic test_reset_wait();
    int lat;
    logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_a = 16'h4321; req_b = 16'h8765; req_op = 3'b010; req_tag = 4'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_count = '0;
    checks++; if ({ScrA, ScrB, AluControl} !== 35'd0 || {rsp_result, rsp_zero, rsp_tag, rsp_err} !== 38'd0) begin
      failures++; $display("FAIL wait_reset_outputs got scra=%h scrb=%h res=%h tag=%0d exp all 0", ScrA, ScrB, rsp_result, rsp_tag);
    end
    checks++; if (rsp_count !== 16'd0 || req_ready !== 1'b1) begin failures++; $display("FAIL wait_reset_state got cnt=%h rdy=%b exp cnt=0 rdy=1", rsp_count, req_ready); end
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL wait_reset_abandon got rsp_valid=1 exp=0"); end
    force dut1.rsp_count = 16'hFFFF;
    #1;
    release dut1.rsp_count;
    #1;
    exp_count = 16'hFFFF;
    checks++; if (rsp_count !== exp_count) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", rsp_count); end
    send(16'h0001, 16'h0002, 3'b001, 4'd1, lat);
    ack();
    checks++; if (rsp_count !== 16'h0000 || rsp_count !== exp_count) begin failures++; $display("FAIL wrap_count got=%h exp=0000", rsp_count); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0; rsp_ready = 1'b0;
    req_valid3 = 1'b0; req_a3 = '0; req_b3 = '0; req_op3 = '0; req_tag3 = '0; rsp_ready3 = 1'b0;
    exp_count = '0;
    test_reset();
    test_basic();
    test_equal();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_latency3();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
